// File: rtl/reg_map_table.sv
`default_nettype none
// ============================================================================
//  Module   : reg_map_table
//  Purpose  : Architectural-to-physical register map for dispatch. Pulls new
//             destination tags from the free list on rename, undoes single
//             renames on ROB rollback, and keeps one full map snapshot per
//             free-list checkpoint column for same-cycle mispredict recovery.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_map_table #(
  parameter int NUM_ARCH_REGS      = 32,
  parameter int NUM_PHYS_REGS      = 64,
  parameter int CHECKPOINT_COLUMNS = 4
) (
  input  logic                                  CLK,
  input  logic                                  nRST,
  output logic                                  DUT_error,
  input  logic [$clog2(NUM_ARCH_REGS)-1:0]      source_arch_reg_tag_A,
  input  logic [$clog2(NUM_ARCH_REGS)-1:0]      source_arch_reg_tag_B,
  output logic [$clog2(NUM_PHYS_REGS)-1:0]      source_phys_reg_tag_A,
  output logic [$clog2(NUM_PHYS_REGS)-1:0]      source_phys_reg_tag_B,
  input  logic                                  rename_valid,
  input  logic [$clog2(NUM_ARCH_REGS)-1:0]      rename_arch_reg_tag,
  output logic                                  rename_ready,
  output logic [$clog2(NUM_PHYS_REGS)-1:0]      rename_new_phys_reg_tag,
  output logic [$clog2(NUM_PHYS_REGS)-1:0]      rename_old_phys_reg_tag,
  output logic                                  free_list_dequeue_valid,
  input  logic [$clog2(NUM_PHYS_REGS)-1:0]      free_list_dequeue_phys_reg_tag,
  input  logic                                  free_list_empty,
  input  logic                                  revert_valid,
  input  logic [$clog2(NUM_ARCH_REGS)-1:0]      revert_arch_reg_tag,
  input  logic [$clog2(NUM_PHYS_REGS)-1:0]      revert_safe_phys_reg_tag,
  input  logic [$clog2(NUM_PHYS_REGS)-1:0]      revert_speculated_phys_reg_tag,
  output logic                                  free_list_revert_valid,
  output logic [$clog2(NUM_PHYS_REGS)-1:0]      free_list_revert_speculated_phys_reg_tag,
  input  logic                                  save_checkpoint_valid,
  input  logic [$clog2(CHECKPOINT_COLUMNS)-1:0] save_checkpoint_column,
  input  logic                                  restore_checkpoint_valid,
  input  logic                                  restore_checkpoint_speculate_failed,
  input  logic [$clog2(CHECKPOINT_COLUMNS)-1:0] restore_checkpoint_column,
  input  logic                                  restore_checkpoint_success
);

  localparam int c_arch_w = $clog2(NUM_ARCH_REGS);
  localparam int c_phys_w = $clog2(NUM_PHYS_REGS);

  // Live map and one snapshot of it per checkpoint column
  logic [c_phys_w-1:0] r_map  [NUM_ARCH_REGS];
  logic [c_phys_w-1:0] r_snap [CHECKPOINT_COLUMNS][NUM_ARCH_REGS];
  logic                r_dut_error;

  logic w_restore_go;
  logic w_restore_take;
  logic w_rename_accept;
  logic w_rename_writes;
  logic w_save_take;
  logic w_revert_bad;
  logic w_error_next;

  // Map-write arbitration: revert > restore > save > rename
  assign w_restore_go    = restore_checkpoint_valid & restore_checkpoint_speculate_failed;
  assign w_restore_take  = w_restore_go & restore_checkpoint_success;
  assign rename_ready    = ~free_list_empty & ~revert_valid & ~w_restore_go & ~save_checkpoint_valid;
  assign w_rename_accept = rename_valid & rename_ready;
  // Arch reg 0 is hardwired to phys 0, so it never consumes a free tag
  assign w_rename_writes = w_rename_accept & (rename_arch_reg_tag != '0);
  assign w_save_take     = save_checkpoint_valid & ~revert_valid & ~w_restore_take;

  // Lookups read the registered map only; a same-cycle write is not bypassed
  assign source_phys_reg_tag_A   = r_map[source_arch_reg_tag_A];
  assign source_phys_reg_tag_B   = r_map[source_arch_reg_tag_B];
  assign rename_old_phys_reg_tag = r_map[rename_arch_reg_tag];
  assign rename_new_phys_reg_tag = (rename_arch_reg_tag != '0) ? free_list_dequeue_phys_reg_tag : '0;
  assign free_list_dequeue_valid = w_rename_writes;

  assign free_list_revert_valid                   = revert_valid;
  assign free_list_revert_speculated_phys_reg_tag = revert_speculated_phys_reg_tag;

  // A rollback must undo exactly the mapping currently held, and never arch 0
  assign w_revert_bad = revert_valid &
                        ((r_map[revert_arch_reg_tag] != revert_speculated_phys_reg_tag) |
                         (revert_arch_reg_tag == '0));
  // Rename while empty cannot happen through rename_ready; kept as a self-check
  assign w_error_next = w_revert_bad | (w_rename_accept & free_list_empty);

  assign DUT_error = r_dut_error;

  // Map, snapshot and error-flag update with identity-map reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_dut_error <= 1'b0;
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
        r_map[i] <= c_phys_w'(i);
        for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
          r_snap[c][i] <= c_phys_w'(i);
        end
      end
    end else begin
      r_dut_error <= w_error_next;

      if (revert_valid) begin
        r_map[revert_arch_reg_tag] <= revert_safe_phys_reg_tag;
      end else if (w_restore_take) begin
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
          r_map[i] <= r_snap[restore_checkpoint_column][i];
        end
      end else if (w_rename_writes) begin
        r_map[rename_arch_reg_tag] <= free_list_dequeue_phys_reg_tag;
      end

      // Snapshot captures the map as it stood before this cycle's update
      if (w_save_take) begin
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
          r_snap[save_checkpoint_column][i] <= r_map[i];
        end
      end
    end
  end

endmodule
`default_nettype wire
